// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Bridges the SPI slave receive path onto the on-chip configuration bus.
// Each 32-bit word delivered by the SPI slave is announced by a toggle on
// spi_tgl (SCLK/SS domain). The toggle is synchronised into clk, the word is
// decoded as a command, and single-write transactions are issued on a
// req/gnt bus. Protocol errors, a two-word long-write sequence, a header
// timeout and a completed-command counter are tracked.
//
// Word format: [31:28] opcode, [27:16] addr, [15:0] imm
//   0x0 NOP       : counted, no bus activity
//   0x1 WR_SHORT  : write zero-extended imm to addr
//   0x2 WR_LONG   : header; the next word is the full write data
//   0x3..0xF      : illegal, word dropped, ill_err set
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   spi_word   in   received SPI word (stable >= 8 clk after spi_tgl changes)
//   spi_tgl    in   word-ready toggle, asynchronous to clk
//   bus_req    out  write request
//   bus_addr   out  write address
//   bus_wdata  out  write data
//   bus_gnt    in   write accepted (only looked at while bus_req=1)
//   busy       out  sequencer not idle
//   cmd_cnt    out  completed commands (NOP or write), wrapping
//   ovr_err    out  sticky: word arrived during a bus transaction
//   ill_err    out  sticky: illegal opcode received
//   to_err     out  sticky: long-write data word never arrived
//   err_clr    in   one-cycle pulse clearing all sticky errors
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] spi_word,
  input  logic                  spi_tgl,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cmd_cnt,
  output logic                  ovr_err,
  output logic                  ill_err,
  output logic                  to_err,
  input  logic                  err_clr
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_WR_SHORT = 4'h1;
  localparam logic [3:0] OP_WR_LONG  = 4'h2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BUS       = 2'd2
  } state_t;

  // Synchroniser and arm phase
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic                  s3_q, s3_d;
  logic [1:0]            arm_q, arm_d;

  // Sequencer state
  state_t                state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

  // Registered outputs
  logic                  bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic                  ovr_err_q, ovr_err_d;
  logic                  ill_err_q, ill_err_d;
  logic                  to_err_q, to_err_d;

  // Decode helpers
  logic                  armed;
  logic                  evt;
  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] word_imm;
  logic                  set_ovr;
  logic                  set_ill;
  logic                  set_to;
  logic                  cnt_inc;

  assign opcode    = spi_word[DATA_WIDTH-1 -: 4];
  assign word_addr = spi_word[16 +: ADDR_WIDTH];
  assign word_imm  = {{(DATA_WIDTH-16){1'b0}}, spi_word[15:0]};

  // The arm counter saturates at 3; until then s3 tracks s2 without an event,
  // so a toggle input already high at reset release is not taken as a word.
  assign armed = (arm_q == 2'd3);
  assign evt   = armed & (s2_q != s3_q);

  always_comb begin
    s1_d        = spi_tgl;
    s2_d        = s1_q;
    s3_d        = s2_q;
    arm_d       = armed ? arm_q : arm_q + 2'd1;

    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    set_ovr     = 1'b0;
    set_ill     = 1'b0;
    set_to      = 1'b0;
    cnt_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (evt) begin
          case (opcode)
            OP_NOP: begin
              cnt_inc = 1'b1;
            end
            OP_WR_SHORT: begin
              state_d     = BUS;
              bus_req_d   = 1'b1;
              bus_addr_d  = word_addr;
              bus_wdata_d = word_imm;
            end
            OP_WR_LONG: begin
              state_d    = WAIT_DATA;
              bus_addr_d = word_addr;
              to_cnt_d   = '0;
            end
            default: begin
              set_ill = 1'b1;
            end
          endcase
        end
      end

      WAIT_DATA: begin
        // A data word arriving on the final count still wins over the timeout.
        if (evt) begin
          state_d     = BUS;
          bus_req_d   = 1'b1;
          bus_wdata_d = spi_word;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
          set_to  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      BUS: begin
        // Words arriving mid-transaction are dropped; the write carries on.
        if (evt) begin
          set_ovr = 1'b1;
        end
        if (bus_gnt) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          cnt_inc   = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    busy_d    = (state_d != IDLE);
    cmd_cnt_d = cnt_inc ? cmd_cnt_q + 1'b1 : cmd_cnt_q;

    // Set takes priority over a simultaneous clear.
    ovr_err_d = set_ovr | (ovr_err_q & ~err_clr);
    ill_err_d = set_ill | (ill_err_q & ~err_clr);
    to_err_d  = set_to  | (to_err_q  & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      arm_q       <= 2'd0;
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      cmd_cnt_q   <= '0;
      ovr_err_q   <= 1'b0;
      ill_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      arm_q       <= arm_d;
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      cmd_cnt_q   <= cmd_cnt_d;
      ovr_err_q   <= ovr_err_d;
      ill_err_q   <= ill_err_d;
      to_err_q    <= to_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;
  assign cmd_cnt   = cmd_cnt_q;
  assign ovr_err   = ovr_err_q;
  assign ill_err   = ill_err_q;
  assign to_err    = to_err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for spi_cmd_sequencer. Expected bus writes are queued when the
// stimulus is driven and compared when the DUT completes each write.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 12;
  localparam int TIMEOUT    = 64;
  localparam int CNT_WIDTH  = 4;

  logic                  clk;
  logic                  reset;
  logic [DATA_WIDTH-1:0] spi_word;
  logic                  spi_tgl;
  logic                  bus_req;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_gnt;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  cmd_cnt;
  logic                  ovr_err;
  logic                  ill_err;
  logic                  to_err;
  logic                  err_clr;

  spi_cmd_sequencer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_word (spi_word),
    .spi_tgl  (spi_tgl),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_gnt  (bus_gnt),
    .busy     (busy),
    .cmd_cnt  (cmd_cnt),
    .ovr_err  (ovr_err),
    .ill_err  (ill_err),
    .to_err   (to_err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DATA_WIDTH-1:0] w);
    spi_word = w;
    spi_tgl  = ~spi_tgl;
  endtask

  task automatic push(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    wr_t e;
    e.addr  = a;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Write completion monitor: a falling bus_req outside reset is a finished write.
  logic                  req_prev  = 1'b0;
  logic [ADDR_WIDTH-1:0] lat_addr  = '0;
  logic [DATA_WIDTH-1:0] lat_wdata = '0;

  always @(negedge clk) begin
    if (reset && req_prev && !bus_req) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 64'(lat_addr), 64'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_addr",  64'(lat_addr),  64'(exp_e.addr));
        check("sb_wdata", 64'(lat_wdata), 64'(exp_e.wdata));
      end
    end
    req_prev  = bus_req;
    lat_addr  = bus_addr;
    lat_wdata = bus_wdata;
  end

  initial begin
    int k;
    int hi;

    // 1: reset with spi_tgl high, no spurious event after release
    reset    = 1'b0;
    spi_tgl  = 1'b1;
    spi_word = '0;
    bus_gnt  = 1'b0;
    err_clr  = 1'b0;
    cyc(3);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_errs",    64'({ovr_err, ill_err, to_err}), 64'd0);
    reset = 1'b1;
    cyc(10);
    check("arm_bus_req", 64'(bus_req), 64'd0);
    check("arm_cmd_cnt", 64'(cmd_cnt), 64'd0);
    check("arm_errs",    64'({ovr_err, ill_err, to_err}), 64'd0);

    // 2: WR_SHORT with grant tied high
    bus_gnt = 1'b1;
    push(12'hABC, 32'h0000_1234);
    send(32'h1ABC_1234);
    k = 0;
    while (!bus_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("short_latency", 64'(k), 64'd3);
    cyc(1);
    check("short_req_1cyc", 64'(bus_req), 64'd0);
    cyc(8);
    check("short_cmd_cnt", 64'(cmd_cnt), 64'd1);

    // 3: WR_LONG, data 20 cycles later, grant after 5 cycles
    bus_gnt = 1'b0;
    send(32'h2055_0000);
    cyc(20);
    check("long_wait_busy", 64'(busy),    64'd1);
    check("long_wait_req",  64'(bus_req), 64'd0);
    push(12'h055, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF);
    k = 0;
    while (!bus_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("long_data_latency", 64'(k), 64'd3);
    hi = 0;
    while (bus_req && hi < 20) begin
      hi++;
      if (hi == 6) bus_gnt = 1'b1;
      @(negedge clk);
    end
    check("long_req_len", 64'(hi), 64'd6);
    cyc(2);
    check("long_idle",    64'(busy),    64'd0);
    check("long_cmd_cnt", 64'(cmd_cnt), 64'd2);

    // 4: header timeout, then a normal short write
    bus_gnt = 1'b0;
    send(32'h2055_0000);
    k = 0;
    while (!to_err && k < TIMEOUT + 20) begin
      @(negedge clk);
      k++;
    end
    check("to_latency", 64'(k), 64'(TIMEOUT + 3));
    check("to_idle",    64'(busy), 64'd0);
    bus_gnt = 1'b1;
    push(12'h001, 32'h0000_0007);
    send(32'h1001_0007);
    cyc(10);
    check("to_after_cmd_cnt", 64'(cmd_cnt), 64'd3);

    // 5: overrun while the bus is stalled
    bus_gnt = 1'b0;
    push(12'h010, 32'h0000_0001);
    send(32'h1010_0001);
    cyc(10);
    send(32'h0000_0000);
    cyc(10);
    check("ovr_set",       64'(ovr_err), 64'd1);
    check("ovr_req_held",  64'(bus_req), 64'd1);
    check("ovr_addr_held", 64'(bus_addr), 64'h010);
    check("ovr_cnt_hold",  64'(cmd_cnt), 64'd3);
    bus_gnt = 1'b1;
    cyc(3);
    check("ovr_cmd_cnt", 64'(cmd_cnt), 64'd4);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("clr_ovr", 64'(ovr_err), 64'd0);
    check("clr_to",  64'(to_err),  64'd0);

    // 7: data word arrives on the last timeout count
    bus_gnt = 1'b1;
    push(12'h0AA, 32'hCAFE_F00D);
    send(32'h20AA_0000);
    cyc(TIMEOUT);
    send(32'hCAFE_F00D);
    cyc(10);
    check("race_no_to",   64'(to_err),  64'd0);
    check("race_cmd_cnt", 64'(cmd_cnt), 64'd5);

    // 6: illegal opcode with a simultaneous clear, then counter wrap
    send(32'h7000_0000);
    cyc(2);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(7);
    check("ill_set_wins", 64'(ill_err), 64'd1);
    check("ill_no_req",   64'(busy),    64'd0);
    check("ill_cmd_cnt",  64'(cmd_cnt), 64'd5);
    for (int i = 0; i < 11; i++) begin
      send(32'h0000_0000);
      cyc(10);
    end
    check("wrap_cmd_cnt", 64'(cmd_cnt), 64'd0);

    // 8: reset in the middle of a stalled write
    bus_gnt = 1'b0;
    send(32'h1123_4567);
    cyc(10);
    check("mid_req_high", 64'(bus_req), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_req_async", 64'(bus_req), 64'd0);
    check("mid_errs",      64'({ovr_err, ill_err, to_err}), 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(10);
    check("mid_after_busy", 64'(busy),    64'd0);
    check("mid_after_cnt",  64'(cmd_cnt), 64'd0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
